// File: rtl/color_adder.sv
// Running 23-bit sum of 8-bit channel samples, accumulated on each sel-qualified edge.
// Optional saturating mode: define COLOR_ADDER_SAT_EN (default build wraps modulo 2^23).
module color_adder (
    input  logic        clk,
    input  logic        rst,
    output logic [22:0] value_out,
    input  logic [7:0]  pixel_in,
    input  logic        sel
);

    logic [22:0] next_value;

`ifdef COLOR_ADDER_SAT_EN
    logic [23:0] sum_ext;

    // The carry out of bit 22 marks a sum past the 23-bit ceiling.
    always_comb begin
        sum_ext    = {1'b0, value_out} + {16'b0, pixel_in};
        next_value = sum_ext[23] ? '1 : sum_ext[22:0];
    end
`else
    always_comb begin
        next_value = value_out + {15'b0, pixel_in};
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_out <= '0;
        end else if (sel) begin
            value_out <= next_value;
        end
    end

endmodule

// File: tb/tb_color_adder.sv
// Directed self-checking bench for color_adder; expected values are hand-computed.
module tb_color_adder;

    logic        clk;
    logic        rst;
    logic [22:0] value_out;
    logic [7:0]  pixel_in;
    logic        sel;

    int unsigned n_checks;
    int unsigned n_errors;

    color_adder dut (
        .clk       (clk),
        .rst       (rst),
        .value_out (value_out),
        .pixel_in  (pixel_in),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", tag, obs, exp);
        end
    endtask

    // Present inputs, then return 1 time unit after the next rising edge.
    task automatic step(input logic s, input logic [7:0] p);
        sel      = s;
        pixel_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned cycles);
        rst = 1'b0;
        sel = 1'b0;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        sel      = 1'b1;
        pixel_in = 8'hFF;

        // Reset held with active sel: output stays zero.
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold", value_out, 23'd0);
        end
        rst = 1'b1;
        sel = 1'b0;

        // Two-sample sum with idle gap.
        step(1'b1, 8'h26);
        check("sum_first", value_out, 23'd38);
        for (int unsigned i = 0; i < 5; i++) begin
            step(1'b0, 8'hAA);
            check("idle_hold", value_out, 23'd38);
        end
        step(1'b1, 8'h79);
        check("sum_second", value_out, 23'd159);

        // Reset between frames.
        rst = 1'b0;
        #1;
        check("rst_async_clear", value_out, 23'd0);
        do_reset(2);
        check("rst_frame", value_out, 23'd0);
        step(1'b1, 8'hCD);
        check("frame2_a", value_out, 23'd205);
        step(1'b1, 8'h6D);
        check("frame2_b", value_out, 23'd314);

        // Asynchronous assertion in the middle of a cycle.
        sel = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("rst_midcycle", value_out, 23'd0);
        do_reset(1);

        // Back-to-back samples, then hold.
        step(1'b1, 8'd1);
        check("b2b_1", value_out, 23'd1);
        step(1'b1, 8'd2);
        check("b2b_2", value_out, 23'd3);
        step(1'b1, 8'd3);
        check("b2b_3", value_out, 23'd6);
        step(1'b1, 8'd4);
        check("b2b_4", value_out, 23'd10);
        for (int unsigned i = 0; i < 3; i++) begin
            step(1'b0, 8'hFF);
            check("b2b_hold", value_out, 23'd10);
        end

        // Full-frame bound and overflow behaviour.
        do_reset(1);
        for (int unsigned i = 0; i < 32768; i++) step(1'b1, 8'hFF);
        check("full_frame", value_out, 23'h7F8000);
        for (int unsigned i = 0; i < 32768; i++) step(1'b1, 8'hFF);
`ifdef COLOR_ADDER_SAT_EN
        check("over_frame", value_out, 23'h7FFFFF);
`else
        check("over_frame", value_out, 23'h7F0000);
`endif
        // 257 * 0xFF = 0xFFFF lifts 0x7F0000 exactly to 0x7FFFFF.
        for (int unsigned i = 0; i < 257; i++) step(1'b1, 8'hFF);
        check("at_ceiling", value_out, 23'h7FFFFF);
        step(1'b1, 8'h01);
`ifdef COLOR_ADDER_SAT_EN
        check("ceiling_plus1", value_out, 23'h7FFFFF);
`else
        check("ceiling_plus1", value_out, 23'h000000);
`endif
        step(1'b0, 8'h00);

        // Sample present while reset is still low is ignored; the next edge adds it.
        rst      = 1'b0;
        sel      = 1'b1;
        pixel_in = 8'h10;
        #1;
        check("rel_clear", value_out, 23'd0);
        @(posedge clk);
        #1;
        check("rel_edge", value_out, 23'd0);
        rst = 1'b1;
        #1;
        check("rel_after", value_out, 23'd0);
        @(posedge clk);
        #1;
        check("rel_first_add", value_out, 23'd16);
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
